// File: rtl/pcs_receive.sv
// 1000BASE-X style PCS receive: turns synchronized 10-bit code-groups into GMII RXD/RX_DV/RX_ER.
// One-group pipeline (r_d1) with the live SUDI input used as lookahead for /T/R/ detection.
`timescale 1ns/1ps
module pcs_receive #(
  parameter logic [7:0] FC_OCTET  = 8'h0E,
  parameter logic [7:0] SOP_OCTET = 8'h55,
  parameter int         CNT_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [9:0]       i_sudi,
  input  logic             i_rx_even,
  input  logic             i_code_sync,
  output logic [7:0]       o_rxd,
  output logic             o_rx_dv,
  output logic             o_rx_er,
  output logic             o_receiving,
  output logic [CNT_W-1:0] o_err_count
);

  // Code-groups written as abcdei_fghj; _N is the RD- column, _P the RD+ column.
  // /I/ is the second group of the idle ordered set (D16.2).
  localparam logic [9:0] K28_5_N = 10'b001111_1010;
  localparam logic [9:0] K28_5_P = 10'b110000_0101;
  localparam logic [9:0] IDLE_N  = 10'b011011_0101;
  localparam logic [9:0] IDLE_P  = 10'b100100_0101;
  localparam logic [9:0] SOP_N   = 10'b110110_1000;
  localparam logic [9:0] SOP_P   = 10'b001001_0111;
  localparam logic [9:0] TERM_N  = 10'b101110_1000;
  localparam logic [9:0] TERM_P  = 10'b010001_0111;
  localparam logic [9:0] EXT_N   = 10'b111010_1000;
  localparam logic [9:0] EXT_P   = 10'b000101_0111;

  typedef enum logic [2:0] {
    CG_DATA,
    CG_COMMA,
    CG_IDLE,
    CG_SOP,
    CG_TERM,
    CG_EXT,
    CG_INVALID
  } cg_t;

  typedef enum logic [2:0] {
    ST_LINK_FAILED,
    ST_WAIT_FOR_K,
    ST_IDLE_D,
    ST_FALSE_CARRIER,
    ST_RECEIVE,
    ST_TRR
  } state_t;

  function automatic logic [8:0] decode_data(input logic [9:0] cg);
    case (cg)
      10'b100111_0100, 10'b011000_1011: decode_data = {1'b1, 8'h00};
      10'b011101_0100, 10'b100010_1011: decode_data = {1'b1, 8'h01};
      10'b101101_1001, 10'b010010_1001: decode_data = {1'b1, 8'h22};
      10'b110001_0101:                  decode_data = {1'b1, 8'h43};
      10'b110101_0011, 10'b001010_1100: decode_data = {1'b1, 8'h64};
      10'b101001_1101, 10'b101001_0010: decode_data = {1'b1, 8'h85};
      10'b011001_1010:                  decode_data = {1'b1, 8'hA6};
      10'b111000_0110, 10'b000111_0110: decode_data = {1'b1, 8'hC7};
      10'b111001_0001, 10'b000110_1110: decode_data = {1'b1, 8'hE8};
      10'b100101_1110, 10'b100101_0001: decode_data = {1'b1, 8'hE9};
      default:                          decode_data = 9'h000;
    endcase
  endfunction

  function automatic logic [7:0] data_octet(input logic [9:0] cg);
    logic [8:0] dd;
    dd = decode_data(cg);
    data_octet = dd[7:0];
  endfunction

  function automatic cg_t classify(input logic [9:0] cg);
    logic [8:0] dd;
    dd = decode_data(cg);
    case (cg)
      K28_5_N, K28_5_P: classify = CG_COMMA;
      IDLE_N,  IDLE_P:  classify = CG_IDLE;
      SOP_N,   SOP_P:   classify = CG_SOP;
      TERM_N,  TERM_P:  classify = CG_TERM;
      EXT_N,   EXT_P:   classify = CG_EXT;
      default:          classify = dd[8] ? CG_DATA : CG_INVALID;
    endcase
  endfunction

  logic [9:0]       r_d1;
  logic             r_d1_even;
  state_t           r_state;
  logic [7:0]       r_rxd;
  logic             r_rx_dv;
  logic             r_rx_er;
  logic             r_receiving;
  logic [CNT_W-1:0] r_err_count;

  cg_t              w_d1_cls;
  cg_t              w_la_cls;
  logic [7:0]       w_d1_octet;

  assign w_d1_cls   = classify(r_d1);
  assign w_la_cls   = classify(i_sudi);
  assign w_d1_octet = data_octet(r_d1);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_d1        <= '0;
      r_d1_even   <= 1'b0;
      r_state     <= ST_LINK_FAILED;
      r_rxd       <= '0;
      r_rx_dv     <= 1'b0;
      r_rx_er     <= 1'b0;
      r_receiving <= 1'b0;
      r_err_count <= '0;
    end else begin
      // RX_EVEN travels with its code-group so the comma test sees a matched pair.
      r_d1      <= i_sudi;
      r_d1_even <= i_rx_even;

      if (r_rx_er && (r_err_count != '1))
        r_err_count <= r_err_count + CNT_W'(1);

      r_rxd       <= '0;
      r_rx_dv     <= 1'b0;
      r_rx_er     <= 1'b0;
      r_receiving <= 1'b0;

      if (!i_code_sync) begin
        // Losing sync inside a packet leaves exactly one error cycle behind.
        r_state <= ST_LINK_FAILED;
        r_rx_er <= r_receiving;
      end else begin
        case (r_state)
          ST_LINK_FAILED: r_state <= ST_WAIT_FOR_K;

          ST_WAIT_FOR_K: begin
            if (w_d1_cls == CG_COMMA && r_d1_even)
              r_state <= ST_IDLE_D;
          end

          ST_IDLE_D: begin
            case (w_d1_cls)
              CG_SOP: begin
                r_rxd       <= SOP_OCTET;
                r_rx_dv     <= 1'b1;
                r_receiving <= 1'b1;
                r_state     <= ST_RECEIVE;
              end
              CG_IDLE, CG_COMMA: r_state <= ST_IDLE_D;
              default: begin
                r_rxd   <= FC_OCTET;
                r_rx_er <= 1'b1;
                r_state <= ST_FALSE_CARRIER;
              end
            endcase
          end

          ST_FALSE_CARRIER: begin
            if (w_d1_cls == CG_IDLE || w_d1_cls == CG_COMMA) begin
              r_state <= ST_IDLE_D;
            end else begin
              r_rxd   <= FC_OCTET;
              r_rx_er <= 1'b1;
            end
          end

          ST_RECEIVE: begin
            case (w_d1_cls)
              CG_DATA: begin
                r_rxd       <= w_d1_octet;
                r_rx_dv     <= 1'b1;
                r_receiving <= 1'b1;
              end
              CG_TERM: begin
                if (w_la_cls == CG_EXT) begin
                  r_state <= ST_TRR;
                end else begin
                  r_rxd       <= r_rxd;
                  r_rx_dv     <= 1'b1;
                  r_rx_er     <= 1'b1;
                  r_receiving <= 1'b1;
                end
              end
              CG_IDLE, CG_COMMA: begin
                r_rx_er <= 1'b1;
                r_state <= ST_IDLE_D;
              end
              default: begin
                r_rxd       <= r_rxd;
                r_rx_dv     <= 1'b1;
                r_rx_er     <= 1'b1;
                r_receiving <= 1'b1;
              end
            endcase
          end

          ST_TRR: begin
            case (w_d1_cls)
              CG_EXT:            r_state <= ST_TRR;
              CG_IDLE, CG_COMMA: r_state <= ST_IDLE_D;
              default: begin
                r_rxd   <= FC_OCTET;
                r_rx_er <= 1'b1;
                r_state <= ST_FALSE_CARRIER;
              end
            endcase
          end

          default: r_state <= ST_LINK_FAILED;
        endcase
      end
    end
  end

  assign o_rxd       = r_rxd;
  assign o_rx_dv     = r_rx_dv;
  assign o_rx_er     = r_rx_er;
  assign o_receiving = r_receiving;
  assign o_err_count = r_err_count;

endmodule

// File: tb/tb_pcs_receive.sv
// Bench for pcs_receive: directed code-group streams, a symbol-level reference model checked
// every cycle on two instances (8-bit and 2-bit error counters), plus literal per-test expectations.
`timescale 1ns/1ps
module tb_pcs_receive;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_req = 1'b1;
  logic [9:0] sudi = '0;
  logic       even = 1'b0;
  logic       sync = 1'b0;

  logic [7:0] rxd_a, rxd_b;
  logic       dv_a, dv_b, er_a, er_b, rcv_a, rcv_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  pcs_receive #(.CNT_W(8)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_sudi(sudi), .i_rx_even(even), .i_code_sync(sync),
    .o_rxd(rxd_a), .o_rx_dv(dv_a), .o_rx_er(er_a), .o_receiving(rcv_a), .o_err_count(cnt_a)
  );

  pcs_receive #(.CNT_W(2)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_sudi(sudi), .i_rx_even(even), .i_code_sync(sync),
    .o_rxd(rxd_b), .o_rx_dv(dv_b), .o_rx_er(er_b), .o_receiving(rcv_b), .o_err_count(cnt_b)
  );

  always #5 clk = ~clk;

  // Code-groups (10-bit, bit a as MSB); N = RD- form, P = RD+ form.
  localparam logic [9:0] K_N = 10'h0FA, K_P = 10'h305;
  localparam logic [9:0] I_N = 10'h1B5, I_P = 10'h245;
  localparam logic [9:0] S_N = 10'h368, S_P = 10'h097;
  localparam logic [9:0] T_N = 10'h2E8, T_P = 10'h117;
  localparam logic [9:0] R_N = 10'h3A8, R_P = 10'h057;
  localparam logic [9:0] BAD = 10'h3FF;

  // Dx.y for the ten data groups used; octet = y*32 + x.
  int         dx[10]   = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  int         dy[10]   = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7};
  logic [9:0] dneg[10] = '{10'h274, 10'h1D4, 10'h2D9, 10'h315, 10'h353,
                           10'h29D, 10'h19A, 10'h386, 10'h391, 10'h25E};
  logic [9:0] dpos[10] = '{10'h18B, 10'h22B, 10'h129, 10'h315, 10'h0AC,
                           10'h292, 10'h19A, 10'h076, 10'h06E, 10'h251};

  localparam int K_DATA = 0, K_COMMA = 1, K_IDLE = 2, K_SOP = 3, K_TERM = 4, K_EXT = 5, K_INV = 6;
  localparam int PH_DOWN = 0, PH_HUNT = 1, PH_IDLE = 2, PH_CARRIER = 3, PH_PACKET = 4, PH_EXTEND = 5;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [7:0] dvq[$];

  // reference model: expected registered outputs after the latest edge
  int         m_ph;
  logic [9:0] m_d1;
  logic       m_d1_even;
  logic [7:0] m_rxd;
  logic       m_dv, m_er, m_rcv;
  int         m_cnt_a, m_cnt_b;

  function automatic int kind_of(input logic [9:0] c, output logic [7:0] oct);
    oct = 8'h00;
    if (c == K_N || c == K_P) return K_COMMA;
    if (c == I_N || c == I_P) return K_IDLE;
    if (c == S_N || c == S_P) return K_SOP;
    if (c == T_N || c == T_P) return K_TERM;
    if (c == R_N || c == R_P) return K_EXT;
    for (int i = 0; i < 10; i++) begin
      if (c == dneg[i] || c == dpos[i]) begin
        oct = 8'(dy[i] * 32 + dx[i]);
        return K_DATA;
      end
    end
    return K_INV;
  endfunction

  task automatic model_reset();
    m_ph = PH_DOWN; m_d1 = '0; m_d1_even = 1'b0;
    m_rxd = '0; m_dv = 1'b0; m_er = 1'b0; m_rcv = 1'b0;
    m_cnt_a = 0; m_cnt_b = 0;
  endtask

  task automatic model_edge();
    logic [7:0] oct, la_oct, n_rxd;
    logic       n_dv, n_er, n_rcv;
    int         k, la;
    if (m_er) begin
      if (m_cnt_a < 255) m_cnt_a++;
      if (m_cnt_b < 3) m_cnt_b++;
    end
    k  = kind_of(m_d1, oct);
    la = kind_of(sudi, la_oct);
    n_rxd = 8'h00; n_dv = 1'b0; n_er = 1'b0; n_rcv = 1'b0;
    if (!sync) begin
      n_er = m_rcv;
      m_ph = PH_DOWN;
    end else begin
      case (m_ph)
        PH_DOWN: m_ph = PH_HUNT;
        PH_HUNT: if (k == K_COMMA && m_d1_even) m_ph = PH_IDLE;
        PH_IDLE: begin
          if (k == K_SOP) begin
            n_rxd = 8'h55; n_dv = 1'b1; n_rcv = 1'b1; m_ph = PH_PACKET;
          end else if (k != K_IDLE && k != K_COMMA) begin
            n_rxd = 8'h0E; n_er = 1'b1; m_ph = PH_CARRIER;
          end
        end
        PH_CARRIER: begin
          if (k == K_IDLE || k == K_COMMA) m_ph = PH_IDLE;
          else begin n_rxd = 8'h0E; n_er = 1'b1; end
        end
        PH_PACKET: begin
          if (k == K_DATA) begin
            n_rxd = oct; n_dv = 1'b1; n_rcv = 1'b1;
          end else if (k == K_TERM && la == K_EXT) begin
            m_ph = PH_EXTEND;
          end else if (k == K_IDLE || k == K_COMMA) begin
            n_er = 1'b1; m_ph = PH_IDLE;
          end else begin
            n_rxd = m_rxd; n_dv = 1'b1; n_er = 1'b1; n_rcv = 1'b1;
          end
        end
        default: begin
          if (k == K_IDLE || k == K_COMMA) m_ph = PH_IDLE;
          else if (k != K_EXT) begin n_rxd = 8'h0E; n_er = 1'b1; m_ph = PH_CARRIER; end
        end
      endcase
    end
    m_rxd = n_rxd; m_dv = n_dv; m_er = n_er; m_rcv = n_rcv;
    m_d1 = sudi; m_d1_even = even;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input logic [9:0] c, input logic ev, input logic sy);
    @(negedge clk);
    rst = rst_req; sudi = c; even = ev; sync = sy;
    @(posedge clk);
    if (rst) model_reset();
    else model_edge();
  endtask

  task automatic idles(input int n);
    for (int i = 0; i < n; i++) begin
      send(K_N, 1'b1, 1'b1);
      send(I_N, 1'b0, 1'b1);
    end
  endtask

  task automatic check_q(input string name, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3, input int len);
    logic [7:0] e[4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({name, "_len"}, 16'(dvq.size()), 16'(len));
    for (int i = 0; i < len && i < dvq.size(); i++)
      check({name, "_rxd"}, 16'(dvq[i]), 16'(e[i]));
  endtask

  // compare process: both instances against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("rxd",         16'(rxd_a), 16'(m_rxd));
      check("rx_dv",       16'(dv_a),  16'(m_dv));
      check("rx_er",       16'(er_a),  16'(m_er));
      check("receiving",   16'(rcv_a), 16'(m_rcv));
      check("err_count8",  16'(cnt_a), 16'(m_cnt_a));
      check("rxd_w2",      16'(rxd_b), 16'(m_rxd));
      check("rx_dv_w2",    16'(dv_b),  16'(m_dv));
      check("rx_er_w2",    16'(er_b),  16'(m_er));
      check("receiving_w2",16'(rcv_b), 16'(m_rcv));
      check("err_count2",  16'(cnt_b), 16'(m_cnt_b));
      if (dv_a === 1'b1) dvq.push_back(rxd_a);
    end
  end

  logic [9:0] c6[7];
  logic [7:0] e6a[7] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
  logic [1:0] e6b[7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

  initial begin
    model_reset();
    rst_req = 1'b1;
    repeat (3) send(I_N, 1'b0, 1'b0);
    chk_en = 1'b1;
    rst_req = 1'b0;
    idles(4);
    $display("reset and link-up done");

    // T1: clean packet
    dvq.delete();
    send(S_N, 1'b0, 1'b1); send(dneg[0], 1'b1, 1'b1); send(dneg[9], 1'b0, 1'b1);
    send(dpos[4], 1'b1, 1'b1); send(T_N, 1'b0, 1'b1); send(R_N, 1'b1, 1'b1);
    idles(2);
    check_q("t1", 8'h55, 8'h00, 8'hE9, 8'h64, 4);
    #1 check("t1_errcnt", 16'(cnt_a), 16'd0);
    $display("test 1 clean packet done");

    // T2: false carrier of two groups
    send(dneg[2], 1'b0, 1'b1); send(dneg[3], 1'b1, 1'b1); send(I_N, 1'b0, 1'b1);
    send(K_N, 1'b1, 1'b1); send(I_P, 1'b0, 1'b1);
    #1 check("t2_errcnt", 16'(cnt_a), 16'd2);
    check("t2_errcnt_w2", 16'(cnt_b), 16'd2);
    $display("test 2 false carrier done");

    // T3: invalid group inside a packet
    dvq.delete();
    send(S_P, 1'b0, 1'b1); send(dpos[1], 1'b1, 1'b1); send(BAD, 1'b0, 1'b1);
    send(dneg[8], 1'b1, 1'b1); send(T_P, 1'b0, 1'b1); send(R_P, 1'b1, 1'b1);
    idles(2);
    check_q("t3", 8'h55, 8'h01, 8'h01, 8'hE8, 4);
    #1 check("t3_errcnt", 16'(cnt_a), 16'd3);
    $display("test 3 invalid in packet done");

    // T4: early end
    send(S_N, 1'b0, 1'b1); send(dneg[5], 1'b1, 1'b1); send(I_N, 1'b0, 1'b1); send(K_N, 1'b1, 1'b1);
    #1 check("t4_er", 16'(er_a), 16'd1);
    check("t4_dv", 16'(dv_a), 16'd0);
    check("t4_rcv", 16'(rcv_a), 16'd0);
    check("t4_rxd", 16'(rxd_a), 16'd0);
    send(I_N, 1'b0, 1'b1);
    #1 check("t4_er_after", 16'(er_a), 16'd0);
    idles(1);
    $display("test 4 early end done");

    // T5: sync loss mid-packet, then odd comma must not relock
    send(S_N, 1'b0, 1'b1); send(dneg[6], 1'b1, 1'b1); send(dneg[7], 1'b0, 1'b0);
    #1 check("t5_er", 16'(er_a), 16'd1);
    check("t5_rcv", 16'(rcv_a), 16'd0);
    check("t5_dv", 16'(dv_a), 16'd0);
    send(dneg[8], 1'b1, 1'b0);
    #1 check("t5_er_after", 16'(er_a), 16'd0);
    send(K_N, 1'b1, 1'b0);
    send(I_N, 1'b0, 1'b1); send(K_N, 1'b0, 1'b1); send(dneg[0], 1'b1, 1'b1);
    send(I_N, 1'b0, 1'b1);
    #1 check("t5_no_fc", 16'(er_a), 16'd0);
    idles(1);
    dvq.delete();
    send(S_N, 1'b0, 1'b1); send(dneg[0], 1'b1, 1'b1); send(T_N, 1'b0, 1'b1); send(R_N, 1'b1, 1'b1);
    idles(2);
    check_q("t5", 8'h55, 8'h00, 8'h00, 8'h00, 2);
    $display("test 5 sync loss done");

    // T7: /T/ without /R/, then carrier after extension
    send(S_N, 1'b0, 1'b1); send(dneg[6], 1'b1, 1'b1); send(T_N, 1'b0, 1'b1);
    send(dneg[0], 1'b1, 1'b1); send(T_N, 1'b0, 1'b1); send(R_N, 1'b1, 1'b1);
    send(dneg[1], 1'b0, 1'b1); send(dneg[2], 1'b1, 1'b1);
    idles(2);
    $display("test 7 terminate variants done");

    // T6a: asynchronous reset mid-packet
    send(S_N, 1'b0, 1'b1); send(dneg[0], 1'b1, 1'b1); send(dneg[1], 1'b0, 1'b1);
    #3 rst = 1'b1; rst_req = 1'b1; model_reset();
    #1 check("t6_rst_dv", 16'(dv_a), 16'd0);
    check("t6_rst_rcv", 16'(rcv_a), 16'd0);
    check("t6_rst_er", 16'(er_a), 16'd0);
    check("t6_rst_rxd", 16'(rxd_a), 16'd0);
    check("t6_rst_cnt", 16'(cnt_a), 16'd0);
    send(I_N, 1'b0, 1'b0); send(I_N, 1'b0, 1'b0);
    rst_req = 1'b0;
    idles(4);

    // T6b: counter progression, 2-bit instance saturates
    c6[0] = dneg[2]; c6[1] = dneg[3]; c6[2] = dneg[4]; c6[3] = dpos[4];
    c6[4] = dneg[9]; c6[5] = I_N; c6[6] = K_N;
    for (int i = 0; i < 7; i++) begin
      send(c6[i], 1'(i % 2), 1'b1);
      #1 check("t6_cnt8", 16'(cnt_a), 16'(e6a[i]));
      check("t6_cnt2", 16'(cnt_b), 16'(e6b[i]));
    end
    idles(2);
    $display("test 6 reset and counter done");

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
